// File: rtl/pe_block_sequencer_if.sv
// Block stream from the PE controller and finished-sum stream toward CNV.
// The master side produces blocks and consumes sums; the slave side is the sequencer.
interface pe_block_sequencer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 32,
    parameter int PSUM_WIDTH  = 15
);
    logic                                    In_Vld;
    logic                                    In_Rdy;
    logic                                    In_First;
    logic                                    In_Last;
    logic [BLOCK_DEPTH-1:0]                  In_FlgAct;
    logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0]  In_Act;
    logic [BLOCK_DEPTH-1:0]                  In_FlgWei;
    logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0]  In_Wei;
    logic                                    Out_Vld;
    logic                                    Out_Rdy;
    logic [PSUM_WIDTH-1:0]                   Out_Mac;

    modport master (
        output In_Vld, In_First, In_Last, In_FlgAct, In_Act, In_FlgWei, In_Wei, Out_Rdy,
        input  In_Rdy, Out_Vld, Out_Mac
    );

    modport slave (
        input  In_Vld, In_First, In_Last, In_FlgAct, In_Act, In_FlgWei, In_Wei, Out_Rdy,
        output In_Rdy, Out_Vld, Out_Mac
    );
endinterface

// File: rtl/pe_block_sequencer.sv
// Double-buffers Act/Wei blocks for one MACAW lane, chains partial sums across the
// blocks of an output point and hands each finished sum to CNV.
module pe_block_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 32,
    parameter int PSUM_WIDTH  = 15
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    pe_block_sequencer_if.slave                    blk,
    output logic                                   PECMAC_Sta,
    output logic [BLOCK_DEPTH-1:0]                 PECMAC_FlgAct,
    output logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0] PECMAC_Act,
    output logic [BLOCK_DEPTH-1:0]                 PECMAC_FlgWei,
    output logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0] PECMAC_Wei,
    output logic [PSUM_WIDTH-1:0]                  MACMAC_Mac,
    input  logic                                   MACPEC_Fnh,
    input  logic [PSUM_WIDTH-1:0]                  MACCNV_Mac,
    output logic                                   Busy
);
    typedef enum logic [2:0] {IDLE, START, WAIT, DRAIN, OUT} state_t;

    typedef struct packed {
        logic                                   first;
        logic                                   last;
        logic [BLOCK_DEPTH-1:0]                 fa;
        logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0] act;
        logic [BLOCK_DEPTH-1:0]                 fw;
        logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0] wei;
    } blk_t;

    state_t                state;
    blk_t                  slot;
    blk_t                  in_blk;
    logic                  full;
    logic                  cur_last;
    logic [PSUM_WIDTH-1:0] acc;
    logic                  out_vld_q;
    logic [PSUM_WIDTH-1:0] out_mac_q;
    logic                  wr;
    logic                  pop;
    logic [PSUM_WIDTH-1:0] reload_base;

    assign in_blk = {blk.In_First, blk.In_Last, blk.In_FlgAct, blk.In_Act,
                     blk.In_FlgWei, blk.In_Wei};

    // In_Rdy is forced low while reset is asserted, otherwise it just mirrors slot space.
    assign blk.In_Rdy  = rst_n & ~full;
    assign blk.Out_Vld = out_vld_q;
    assign blk.Out_Mac = out_mac_q;
    assign Busy        = (state != IDLE) | full;

    assign wr  = blk.In_Vld & blk.In_Rdy;
    // A pop is always a reload of the operand regs and launches the next START.
    assign pop = full & ((state == IDLE) |
                         ((state == DRAIN) & ~cur_last) |
                         ((state == OUT) & blk.Out_Rdy));
    // In DRAIN the sum being retired is still on MACCNV_Mac, not yet in acc.
    assign reload_base = (state == DRAIN) ? MACCNV_Mac : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            slot          <= '0;
            full          <= 1'b0;
            cur_last      <= 1'b0;
            acc           <= '0;
            PECMAC_Sta    <= 1'b0;
            PECMAC_FlgAct <= '0;
            PECMAC_Act    <= '0;
            PECMAC_FlgWei <= '0;
            PECMAC_Wei    <= '0;
            MACMAC_Mac    <= '0;
            out_vld_q     <= 1'b0;
            out_mac_q     <= '0;
        end else begin
            PECMAC_Sta <= pop;

            if (wr) begin
                slot <= in_blk;
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end

            if (pop) begin
                PECMAC_FlgAct <= slot.fa;
                PECMAC_Act    <= slot.act;
                PECMAC_FlgWei <= slot.fw;
                PECMAC_Wei    <= slot.wei;
                cur_last      <= slot.last;
                MACMAC_Mac    <= slot.first ? '0 : reload_base;
            end

            case (state)
                IDLE:  if (full) state <= START;
                START: state <= WAIT;
                WAIT:  if (MACPEC_Fnh) state <= DRAIN;
                DRAIN: begin
                    acc <= MACCNV_Mac;
                    if (cur_last) begin
                        out_vld_q <= 1'b1;
                        out_mac_q <= MACCNV_Mac;
                        state     <= OUT;
                    end else begin
                        state <= full ? START : IDLE;
                    end
                end
                OUT: if (blk.Out_Rdy) begin
                    out_vld_q <= 1'b0;
                    state     <= full ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
